// File: rtl/mmm_pkg.sv
// Shared definitions for the Montgomery iteration controller: default operand
// width, FSM state encoding and the iteration-counter width helper.
package mmm_pkg;

  localparam int MMM_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ITER  = 2'd2,
    S_FINAL = 2'd3
  } mmm_state_e;

  // Counter only has to reach WIDTH-1; keep at least one bit for tiny widths.
  function automatic int mmm_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mmm_iter_ctrl_pe_add.sv
// Combinational Montgomery processing element: quotient bit and unshifted
// partial sum reg_rji + ai*b + qi*m.
module mmm_pe_add
  import mmm_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH
) (
  input  logic [WIDTH+1:0] reg_rji,
  input  logic             ai,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             qi,
  output logic [WIDTH+1:0] rjo
);

  always_comb begin
    qi  = reg_rji[0] ^ (ai & b[0]);
    // Accumulator stays below 2M, so the sum below 4M fits in WIDTH+2 bits.
    rjo = reg_rji
        + (ai ? {2'b00, b} : '0)
        + (qi ? {2'b00, m} : '0);
  end

endmodule

// File: rtl/mmm_iter_ctrl.sv
// Bit-serial Montgomery multiplication controller driving an external shift
// register. Define MMM_FINAL_SUB_EN to add the final conditional subtraction.
//
// state | meaning
// IDLE  | waiting for start, operands captured on start
// LOAD  | clear downstream accumulator, reset iteration counter
// ITER  | one Montgomery step per cycle, WIDTH cycles
// FINAL | latch result, pulse done
module mmm_iter_ctrl
  import mmm_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH+1:0] reg_rji,
  output logic [WIDTH+1:0] rjo,
  output logic             ld_a,
  output logic             en_o,
  output logic             rst_mmm_o,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result
);

  localparam int CW = mmm_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mmm_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             done_q, done_d;
  logic             rst_mmm_q, rst_mmm_d;
  logic [WIDTH:0]   final_val;
  logic             qi;

  mmm_pe_add #(.WIDTH(WIDTH)) u_pe_add (
    .reg_rji (reg_rji),
    .ai      (a_sh_q[0]),
    .b       (b_q),
    .m       (m_q),
    .qi      (qi),
    .rjo     (rjo)
  );

`ifdef MMM_FINAL_SUB_EN
  always_comb begin
    if (reg_rji >= {2'b00, m_q}) final_val = (WIDTH+1)'(reg_rji - {2'b00, m_q});
    else                         final_val = reg_rji[WIDTH:0];
  end
`else
  assign final_val = reg_rji[WIDTH:0];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_d       = b_q;
    m_d       = m_q;
    result_d  = result_q;
    done_d    = done_q;
    rst_mmm_d = 1'b1;
    if (en) begin
      done_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_d  = a;
            b_d     = b;
            m_d     = m;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_d   = '0;
          state_d = S_ITER;
        end
        S_ITER: begin
          a_sh_d = a_sh_q >> 1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_FINAL;
        end
        S_FINAL: begin
          result_d = final_val;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // Abort overrides whatever the active state decided; IDLE ignores it.
      if (abort && (state_q != S_IDLE)) begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        result_d  = result_q;
        done_d    = 1'b0;
        rst_mmm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_q       <= '0;
      m_q       <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      rst_mmm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_q       <= b_d;
      m_q       <= m_d;
      result_q  <= result_d;
      done_q    <= done_d;
      rst_mmm_q <= rst_mmm_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ld_a      = (state_q == S_LOAD);
  assign en_o      = en && !abort && ((state_q == S_LOAD) || (state_q == S_ITER));
  assign rst_mmm_o = rst_mmm_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mmm_iter_ctrl.sv
// Scoreboard bench for mmm_iter_ctrl paired with a behavioural downstream
// accumulator shift register; expected results from modular arithmetic.
module tb_mmm_iter_ctrl;

  localparam int WIDTH = 8;

  logic             clk, rstb, en, start, abort;
  logic [WIDTH-1:0] a_i, b_i, m_i;
  logic [WIDTH+1:0] reg_rji, rjo;
  logic             ld_a, en_o, rst_mmm_o, busy, done;
  logic [WIDTH:0]   result;

  typedef struct {
    int r;
    int m;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mmm_iter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .start     (start),
    .abort     (abort),
    .a         (a_i),
    .b         (b_i),
    .m         (m_i),
    .reg_rji   (reg_rji),
    .rjo       (rjo),
    .ld_a      (ld_a),
    .en_o      (en_o),
    .rst_mmm_o (rst_mmm_o),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream shift register: cleared by rst_mmm_o or ld_a, else loads rjo/2.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)            reg_rji <= '0;
    else if (!rst_mmm_o)  reg_rji <= '0;
    else if (en_o)        reg_rji <= ld_a ? '0 : (rjo >> 1);
  end

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  // A*B*2^-WIDTH mod M: the x in [0,M) with x*2^WIDTH == A*B (mod M).
  function automatic int mont_ref(input int av, input int bv, input int mv);
    int t;
    t = (av * bv) % mv;
    for (int x = 0; x < mv; x++)
      if (((x << WIDTH) % mv) == t) return x;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rstb && done) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
`ifdef MMM_FINAL_SUB_EN
        check(int'(result) == e.r, "result", int'(result), e.r);
`else
        check((int'(result) % e.m == e.r) && (int'(result) < 2 * e.m),
              "result_mod", int'(result), e.r);
`endif
      end
    end
  end

  task automatic run_op(input int av, input int bv, input int mv,
                        input int stall_at, input int stall_len, input bit poke);
    int lat, en_cnt, ld_cnt;
    bit seen;
    logic [WIDTH:0] r_done;
    exp_q.push_back('{mont_ref(av, bv, mv), mv});
    @(negedge clk);
    a_i = WIDTH'(av); b_i = WIDTH'(bv); m_i = WIDTH'(mv); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; en_cnt = 0; ld_cnt = 0; seen = 1'b0; r_done = '0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      if (en_o) en_cnt++;
      if (ld_a) ld_cnt++;
      if (done) begin seen = 1'b1; r_done = result; end
      if (!seen) begin
        @(posedge clk); lat++; #1;
        if (stall_len > 0 && lat == stall_at) en = 1'b0;
        if (stall_len > 0 && lat == stall_at + stall_len) en = 1'b1;
        if (poke && lat == 5) start = 1'b1;
        if (poke && lat == 6) start = 1'b0;
      end
    end
    en = 1'b1; start = 1'b0;
    check(seen && lat == WIDTH + 2 + stall_len, "done_latency", lat, WIDTH + 2 + stall_len);
    check(en_cnt == WIDTH + 1, "en_o_cycles", en_cnt, WIDTH + 1);
    check(ld_cnt == 1, "ld_a_cycles", ld_cnt, 1);
    repeat (3) @(negedge clk);
    check(result == r_done, "result_hold", result, r_done);
    check(busy == 1'b0, "idle_after_run", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int av, bv, mv, lat, ndone, l1, l2;
    rstb = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0;
    a_i = '0; b_i = '0; m_i = '0;
    #1;
    check({busy, done, ld_a, en_o, rst_mmm_o} == 5'b0, "reset_ctrl", {busy, done, ld_a, en_o, rst_mmm_o}, 0);
    check(result == '0, "reset_result", result, 0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(posedge clk); #1;
    check(rst_mmm_o == 1'b1, "rst_mmm_release", rst_mmm_o, 1);

    run_op(5, 7, 13, 0, 0, 1'b0);
    run_op(0, 7, 13, 0, 0, 1'b0);
    check(result == '0, "zero_operand", result, 0);
    run_op(5, 7, 13, 4, 3, 1'b0);
    run_op(12, 12, 13, 0, 0, 1'b1);

    // abort in ITER
    @(negedge clk);
    a_i = 8'd9; b_i = 8'd11; m_i = 8'd13; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check(rst_mmm_o == 1'b0, "abort_rst_mmm_low", rst_mmm_o, 0);
    check(busy == 1'b0, "abort_busy", busy, 0);
    check(done == 1'b0, "abort_no_done", done, 0);
    @(posedge clk); #1;
    check(rst_mmm_o == 1'b1, "abort_rst_mmm_release", rst_mmm_o, 1);
    repeat (15) @(negedge clk);
    run_op(9, 11, 13, 0, 0, 1'b0);

    // abort and start together in IDLE: start wins
    @(negedge clk);
    a_i = 8'd3; b_i = 8'd4; m_i = 8'd13; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check(busy == 1'b1 && rst_mmm_o == 1'b1, "idle_abort_ignored", {busy, rst_mmm_o}, 3);
    exp_q.push_back('{mont_ref(3, 4, 13), 13});
    repeat (14) @(negedge clk);

    // reset mid-run
    @(negedge clk);
    a_i = 8'd7; b_i = 8'd8; m_i = 8'd11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rstb = 1'b0;
    #1;
    check({busy, done, ld_a, en_o, rst_mmm_o} == 5'b0, "midrun_reset_ctrl", {busy, done, ld_a, en_o, rst_mmm_o}, 0);
    check(result == '0, "midrun_reset_result", result, 0);
    @(negedge clk); rstb = 1'b1;
    repeat (15) @(negedge clk);

    // back-to-back runs with start held high
    exp_q.push_back('{mont_ref(100, 200, 211), 211});
    exp_q.push_back('{mont_ref(100, 200, 211), 211});
    @(negedge clk);
    a_i = 8'd100; b_i = 8'd200; m_i = 8'd211; start = 1'b1;
    @(posedge clk); #1;
    lat = 0; ndone = 0; l1 = -1; l2 = -1;
    while (ndone < 2 && lat < 40) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) l1 = lat; else l2 = lat;
      end
      @(posedge clk); lat++; #1;
      if (lat == 12) start = 1'b0;
    end
    start = 1'b0;
    check(l1 == WIDTH + 2, "b2b_first_done", l1, WIDTH + 2);
    check(l2 == 2 * WIDTH + 5, "b2b_second_done", l2, 2 * WIDTH + 5);
    repeat (15) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      mv = 2 * $urandom_range(1, 127) + 1;
      av = $urandom_range(0, mv - 1);
      bv = $urandom_range(0, mv - 1);
      run_op(av, bv, mv, $urandom_range(1, 8), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmm_iter_ctrl.md
MMM_ITER_CTRL -- requirements
Module: mmm_iter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstb, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: global stall; when low, all state and outputs hold.
REQ-005 SHALL have port start, input, 1 bit: request a new multiplication; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: synchronous cancel of a run in progress.
REQ-007 SHALL have ports a, b and m, each input, WIDTH bits: operands A, B and odd modulus M, with A<M and B<M.
REQ-008 SHALL have port reg_rji, input, WIDTH+2 bits: accumulator fed back from the downstream shift register.
REQ-009 SHALL have port rjo, output, WIDTH+2 bits: unshifted partial sum driven to the downstream shift register.
REQ-010 SHALL have port ld_a, output, 1 bit: clear request to the downstream shift register.
REQ-011 SHALL have port en_o, output, 1 bit: load enable to the downstream shift register.
REQ-012 SHALL have port rst_mmm_o, output, 1 bit: active-low clear to the downstream shift register.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-015 SHALL have port result, output, WIDTH+1 bits: A*B*2^-WIDTH mod M.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, ITER and FINAL; every transition is qualified by en=1.
REQ-017 SHALL, in IDLE with start=1, capture a into a shift register and b, m into holding registers, then go to LOAD.
REQ-018 SHALL, in LOAD, drive ld_a=1 and en_o=1 for one cycle, clear the iteration counter and go to ITER.
REQ-019 SHALL, in ITER, drive en_o=1 and ld_a=0 and compute with ai = a_sh[0]: qi = (reg_rji[0] XOR (ai AND b[0])); rjo = reg_rji + ai*b + qi*m, zero-extended to WIDTH+2 bits with no overflow.
REQ-020 SHALL, in ITER, shift a_sh right by one bit per cycle and increment the counter; after WIDTH ITER cycles it goes to FINAL.
REQ-021 SHALL, in FINAL, register result from reg_rji, pulse done=1 for exactly one cycle and return to IDLE.
REQ-022 SHALL produce its first done at the WIDTH+2 rising edge after the edge that samples start (edge 10 for WIDTH=8), given en held high.
REQ-023 SHALL drive en_o=0 and ld_a=0 in IDLE and FINAL, and drive en_o=0 whenever en=0.
REQ-024 SHALL, on abort=1 in LOAD, ITER or FINAL, drive rst_mmm_o=0 for one cycle, go to IDLE without pulsing done, and leave result unchanged.
REQ-025 SHALL ignore abort in IDLE; when abort and start are high together in IDLE, start wins.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL hold result stable between done pulses.

Reset
REQ-028 SHALL, while rstb=0, force IDLE, counter=0, a_sh=0, result=0, done=0, busy=0, ld_a=0, en_o=0 and rst_mmm_o=0.
REQ-029 SHALL, on rstb deassertion, release rst_mmm_o to 1, and a reset taken mid-run SHALL discard that run with no done pulse.

Configuration
REQ-030 SHALL, with MMM_FINAL_SUB_EN defined, set result = reg_rji - m when reg_rji >= m, else reg_rji, so result < M and result[WIDTH]=0.
REQ-031 SHALL, without MMM_FINAL_SUB_EN, set result = reg_rji[WIDTH:0] unreduced, giving result < 2M and result congruent to the reduced value mod M.

Structure
REQ-032 SHALL take its FSM state enum and the WIDTH default from the shared package mmm_pkg.
REQ-033 SHALL instantiate one combinational sub-module, mmm_pe_add, computing qi and rjo from reg_rji, ai, b and m.

Verification
REQ-034 Bench SHALL pair the block with the existing downstream shift register and cover these scenarios.
REQ-035 WIDTH=8, M=13, A=5, B=7, start pulse with MMM_FINAL_SUB_EN -> done at edge 10, result=1.
REQ-036 A=0, B=7, M=13 -> result=0; ld_a=1 in LOAD only; en_o=1 for exactly 9 cycles.
REQ-037 en low for 3 cycles mid-ITER -> done is delayed by exactly 3 cycles and result is unchanged (1).
REQ-038 abort at ITER cycle 4 -> rst_mmm_o=0 for one cycle, no done, busy=0 next cycle; a following start gives the correct result.
REQ-039 rstb pulled low mid-ITER -> all outputs reach their reset values immediately; start while busy is ignored; back-to-back runs with start held high give one done per run.
